// File: rtl/dmem_bridge_pkg.sv
// Shared types and constants for the data-memory bridge: FSM encoding,
// bus access sizes and kseg segment codes used by address translation.
package dmem_bridge_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned SIZE_W = 2;
  localparam int unsigned SEG_W  = 3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_e;

  localparam logic [SIZE_W-1:0] SIZE_BYTE = SIZE_W'(0);
  localparam logic [SIZE_W-1:0] SIZE_HALF = SIZE_W'(1);
  localparam logic [SIZE_W-1:0] SIZE_WORD = SIZE_W'(2);

  localparam logic [SEG_W-1:0] KSEG0_SEG = 3'b100;
  localparam logic [SEG_W-1:0] KSEG1_SEG = 3'b101;

endpackage

// File: rtl/dmem_bridge_vaddr_map.sv
// Combinational virtual-to-physical address map. With DMEM_ADDR_MAP_EN
// defined, kseg0/kseg1 addresses drop their top three bits; otherwise pass-through.
module vaddr_map
  import dmem_bridge_pkg::*;
(
  input  logic [ADDR_W-1:0] vaddr_i,
  output logic [ADDR_W-1:0] paddr_o
);

`ifdef DMEM_ADDR_MAP_EN
  always_comb begin
    paddr_o = vaddr_i;
    if (vaddr_i[ADDR_W-1 -: SEG_W] == KSEG0_SEG || vaddr_i[ADDR_W-1 -: SEG_W] == KSEG1_SEG) begin
      paddr_o = {SEG_W'(0), vaddr_i[ADDR_W-SEG_W-1:0]};
    end
  end
`else
  assign paddr_o = vaddr_i;
`endif

endmodule

// File: rtl/dmem_bridge.sv
// M-stage load/store to request/addr_ok/data_ok bus bridge, one transaction
// in flight. Address translation selected by DMEM_ADDR_MAP_EN (see vaddr_map).
module dmem_bridge
  import dmem_bridge_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_en,
  input  logic              memwriteM,
  input  logic [SIZE_W-1:0] mem_size,
  input  logic [3:0]        sig_write,
  input  logic [ADDR_W-1:0] aluoutM,
  input  logic [DATA_W-1:0] writedataM,
  input  logic              longest_stall,
  output logic [DATA_W-1:0] readdataM,
  output logic              stall_mem,
  output logic              data_req,
  output logic              data_wr,
  output logic [SIZE_W-1:0] data_size,
  output logic [ADDR_W-1:0] data_addr,
  output logic [DATA_W-1:0] data_wdata,
  input  logic              data_addr_ok,
  input  logic              data_data_ok,
  input  logic [DATA_W-1:0] data_rdata
);

  state_e              state_q, state_d;
  logic                req_q, req_d;
  logic                wr_q, wr_d;
  logic [SIZE_W-1:0]   size_q, size_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [ADDR_W-1:0]   paddr;

  // The bus has no strobe lines: lanes follow from data_size and the address.
  logic unused_sig_write;
  assign unused_sig_write = ^sig_write;

  vaddr_map u_vaddr_map (
    .vaddr_i (aluoutM),
    .paddr_o (paddr)
  );

  // Next-state, request latch, read capture and the combinational stall.
  always_comb begin
    state_d   = state_q;
    wr_d      = wr_q;
    size_d    = size_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    stall_mem = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (mem_en) begin
          stall_mem = 1'b1;
          wr_d      = memwriteM;
          size_d    = mem_size;
          addr_d    = paddr;
          wdata_d   = writedataM;
          state_d   = S_REQ;
        end
      end
      S_REQ: begin
        stall_mem = 1'b1;
        if (data_addr_ok) begin
          if (data_data_ok) begin
            state_d = S_DONE;
            if (!wr_q) rdata_d = data_rdata;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        stall_mem = 1'b1;
        if (data_data_ok) begin
          state_d = S_DONE;
          if (!wr_q) rdata_d = data_rdata;
        end
      end
      S_DONE: begin
        // Pipeline still held elsewhere: keep the result, ignore new mem_en.
        if (!longest_stall) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    req_d = (state_d == S_REQ);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      req_q   <= 1'b0;
      wr_q    <= 1'b0;
      size_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      wr_q    <= wr_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  assign readdataM  = rdata_q;
  assign data_req   = req_q;
  assign data_wr    = wr_q;
  assign data_size  = size_q;
  assign data_addr  = addr_q;
  assign data_wdata = wdata_q;

endmodule

// File: tb/tb_dmem_bridge.sv
// Directed bench for dmem_bridge: expected outputs per cycle come from each
// transaction's handshake schedule, plus literal pins on key values.
module tb_dmem_bridge;
  import dmem_bridge_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_en, memwriteM, longest_stall;
  logic [1:0]  mem_size;
  logic [3:0]  sig_write;
  logic [31:0] aluoutM, writedataM;
  logic [31:0] readdataM;
  logic        stall_mem, data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;

  always #5 clk = ~clk;

  dmem_bridge dut (
    .clk           (clk),
    .rst           (rst),
    .mem_en        (mem_en),
    .memwriteM     (memwriteM),
    .mem_size      (mem_size),
    .sig_write     (sig_write),
    .aluoutM       (aluoutM),
    .writedataM    (writedataM),
    .longest_stall (longest_stall),
    .readdataM     (readdataM),
    .stall_mem     (stall_mem),
    .data_req      (data_req),
    .data_wr       (data_wr),
    .data_size     (data_size),
    .data_addr     (data_addr),
    .data_wdata    (data_wdata),
    .data_addr_ok  (data_addr_ok),
    .data_data_ok  (data_data_ok),
    .data_rdata    (data_rdata)
  );

  int checks = 0;
  int errors = 0;

  logic        chk_en = 1'b0;
  logic        exp_stall, exp_req, exp_wr;
  logic [1:0]  exp_size;
  logic [31:0] exp_addr, exp_wdata, exp_rdata;

  // Model of what the bridge currently holds (last latched request, last load data).
  logic        cur_wr = 1'b0;
  logic [1:0]  cur_size = 2'd0;
  logic [31:0] cur_addr = '0, cur_wdata = '0, cur_rdata = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("stall_mem",  32'(stall_mem),  32'(exp_stall));
      chk("data_req",   32'(data_req),   32'(exp_req));
      chk("data_wr",    32'(data_wr),    32'(exp_wr));
      chk("data_size",  32'(data_size),  32'(exp_size));
      chk("data_addr",  data_addr,       exp_addr);
      chk("data_wdata", data_wdata,      exp_wdata);
      chk("readdataM",  readdataM,       exp_rdata);
    end
  end

  function automatic logic [31:0] map_addr(input logic [31:0] a);
`ifdef DMEM_ADDR_MAP_EN
    if (a[31:29] == KSEG0_SEG || a[31:29] == KSEG1_SEG) return {3'b000, a[28:0]};
`endif
    return a;
  endfunction

  // One transaction: mem_en at k=0, addr_ok at k=1+alat, data_ok dlat cycles
  // later, then longest_stall held for `hold` cycles in the completion phase.
  task automatic run_txn(input logic wr, input logic [1:0] sz, input logic [3:0] sw,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] rd, input int alat, input int dlat,
                         input int hold, input logic keep_en);
    int ta, td, last;
    logic [31:0] new_rd;
    ta     = 1 + alat;
    td     = ta + dlat;
    last   = td + 1 + hold;
    new_rd = wr ? cur_rdata : rd;
    for (int k = 0; k <= last + 1; k++) begin
      @(posedge clk); #1;
      if (k == 0) begin
        mem_en     = 1'b1;
        memwriteM  = wr;
        mem_size   = sz;
        sig_write  = sw;
        aluoutM    = addr;
        writedataM = wdata;
      end else begin
        mem_en     = (keep_en && k <= td) || (k > td && k <= last);
        memwriteM  = 1'($urandom);
        mem_size   = 2'($urandom);
        sig_write  = 4'($urandom);
        aluoutM    = $urandom;
        writedataM = $urandom;
      end
      data_addr_ok  = (k == ta);
      data_data_ok  = (k == td);
      data_rdata    = (k == td) ? rd : $urandom;
      longest_stall = (k > td && k < last) || (k <= td && (k % 2 == 1));
      if (k == 1) begin
        cur_wr    = wr;
        cur_size  = sz;
        cur_addr  = map_addr(addr);
        cur_wdata = wdata;
      end
      if (k == td + 1) cur_rdata = new_rd;
      exp_stall = (k <= td);
      exp_req   = (k >= 1 && k <= ta);
      exp_wr    = cur_wr;
      exp_size  = cur_size;
      exp_addr  = cur_addr;
      exp_wdata = cur_wdata;
      exp_rdata = cur_rdata;
      chk_en    = 1'b1;
    end
  endtask

  initial begin
    rst = 1'b1;
    mem_en = 1'b0; memwriteM = 1'b0; mem_size = 2'd0; sig_write = 4'd0;
    aluoutM = '0; writedataM = '0; longest_stall = 1'b0;
    data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_readdataM", readdataM, 32'h0);
    chk("rst_data_req",  32'(data_req), 32'h0);
    chk("rst_stall_mem", 32'(stall_mem), 32'h0);
    chk("rst_data_addr", data_addr, 32'h0);
    rst = 1'b0;

    // Word load, minimum latency.
    run_txn(1'b0, SIZE_WORD, 4'b1111, 32'h8000_0010, 32'h1111_2222, 32'hDEAD_BEEF, 0, 1, 0, 1'b1);
    chk("lit_load_rdata", readdataM, 32'hDEAD_BEEF);
`ifdef DMEM_ADDR_MAP_EN
    chk("lit_load_addr", data_addr, 32'h0000_0010);
`else
    chk("lit_load_addr", data_addr, 32'h8000_0010);
`endif

    // Byte store, addr_ok late (data_req held 3 cycles), mem_en dropped after issue.
    run_txn(1'b1, SIZE_BYTE, 4'b0100, 32'h1000_0002, 32'h00AB_0000, 32'h5555_5555, 2, 1, 0, 1'b0);
    chk("lit_store_rdata", readdataM, 32'hDEAD_BEEF);
    chk("lit_store_wr",    32'(data_wr), 32'h1);
    chk("lit_store_wdata", data_wdata, 32'h00AB_0000);

    // Same-cycle addr_ok/data_ok; kseg1 address exercises the map.
    run_txn(1'b0, SIZE_HALF, 4'b0011, 32'hA000_0040, 32'h0, 32'h1234_5678, 0, 0, 0, 1'b1);
    chk("lit_same_rdata", readdataM, 32'h1234_5678);
`ifdef DMEM_ADDR_MAP_EN
    chk("lit_kseg1_addr", data_addr, 32'h0000_0040);
`else
    chk("lit_kseg1_addr", data_addr, 32'hA000_0040);
`endif

    // Completion held by longest_stall for 4 cycles with mem_en asserted.
    run_txn(1'b0, SIZE_WORD, 4'b1111, 32'h0000_0100, 32'h0, 32'hCAFE_F00D, 1, 2, 4, 1'b1);
    chk("lit_hold_rdata", readdataM, 32'hCAFE_F00D);

    // Store with an unusual lane pattern still completes.
    run_txn(1'b1, SIZE_WORD, 4'b1010, 32'h2000_0008, 32'h0BAD_F00D, 32'h0, 1, 1, 0, 1'b1);

    // Reset while a load waits for data_ok.
    chk_en = 1'b0;
    @(posedge clk); #1;
    mem_en = 1'b1; memwriteM = 1'b0; mem_size = SIZE_WORD; aluoutM = 32'h0000_0200;
    data_addr_ok = 1'b0; data_data_ok = 1'b0; longest_stall = 1'b0;
    @(posedge clk); #1;
    data_addr_ok = 1'b1;
    #1 chk("rst_txn_req", 32'(data_req), 32'h1);
    @(posedge clk); #1;
    data_addr_ok = 1'b0; mem_en = 1'b0;
    chk("rst_txn_wait_stall", 32'(stall_mem), 32'h1);
    #2 rst = 1'b1;
    #1;
    chk("midrst_data_req",  32'(data_req), 32'h0);
    chk("midrst_readdataM", readdataM, 32'h0);
    chk("midrst_stall_mem", 32'(stall_mem), 32'h0);
    chk("midrst_data_addr", data_addr, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    data_data_ok = 1'b1; data_rdata = 32'h7777_7777;
    @(posedge clk); #1;
    data_data_ok = 1'b0;
    chk("stray_ok_readdataM", readdataM, 32'h0);
    chk("stray_ok_stall",     32'(stall_mem), 32'h0);
    cur_wr = 1'b0; cur_size = 2'd0; cur_addr = '0; cur_wdata = '0; cur_rdata = '0;
    run_txn(1'b0, SIZE_WORD, 4'b1111, 32'h0000_0300, 32'h0, 32'h0A0B_0C0D, 0, 1, 0, 1'b1);
    chk("lit_after_rst_rdata", readdataM, 32'h0A0B_0C0D);

    chk_en = 1'b0;
    @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
